// File: rtl/lii_out_arbiter.sv
// -----------------------------------------------------------------------------
// lii_out_arbiter
//
// Shares one LII phy output channel among N kernel-side AXI-Stream outputs.
// Arbitration is round-robin. A grant is held for a whole packet, up to and
// including the tlast beat. Each accepted beat is zero-extended from W to PW
// bits and stamped with a source ID (LOCAL_ID) and a destination ID. The
// destination ID comes from a runtime-writable per-input table. The stamped
// beat is held in a single output register.
//
// Ports
//   aclk, arst       clock, synchronous active-high reset
//   s_tdata          N*W packed payloads, input i at [i*W +: W]
//   s_tvalid/tlast   per-input valid / end-of-packet
//   s_tready         per-input ready (only the granted input, only in LOCKED)
//   cfg_we/idx/dst   destination-table write port (idx >= N ignored)
//   lii_out_tdata    registered PW-bit beat
//   lii_out_tvalid   output valid
//   lii_out_tready   phy ready
//   lii_out_src      constant LOCAL_ID
//   lii_out_dst      destination ID captured with the beat
//   busy             FSM is in LOCKED
//   grant_idx        current / most recent grant
// -----------------------------------------------------------------------------
module lii_out_arbiter #(
  parameter int          N        = 4,
  parameter int          W        = 72,
  parameter int          PW       = 128,
  parameter logic [7:0]  LOCAL_ID = 8'h00,
  localparam int         IW       = $clog2(N)
) (
  input  logic            aclk,
  input  logic            arst,
  input  logic [N*W-1:0]  s_tdata,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [7:0]      cfg_dst,
  output logic [PW-1:0]   lii_out_tdata,
  output logic            lii_out_tvalid,
  input  logic            lii_out_tready,
  output logic [7:0]      lii_out_src,
  output logic [7:0]      lii_out_dst,
  output logic            busy,
  output logic [IW-1:0]   grant_idx
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [N-1:0]    w_tready;
  logic            w_acc;
  logic [W-1:0]    w_payload;
  logic [PW-1:0]   w_ext;
  logic [7:0]      r_dst_tab [N];

  logic [PW-1:0]   r_tdata_p0;
  logic [7:0]      r_dst_p0;
  logic            r_vld_p0;

  // Index of the k-th candidate after the pointer, wrapping modulo N.
  // The pointer entry itself is visited last, which gives the fairness rule.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + 1 + k) % N;
    return IW'(s);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && s_tvalid[rr_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = rr_idx(r_ptr, k);
      end
    end
  end

  assign w_payload = s_tdata[int'(r_grant)*W +: W];

  always_comb begin
    w_ext          = '0;
    w_ext[W-1:0]   = w_payload;
  end

  // Next state and ready. lii_out_tready -> s_tready is the only
  // combinational path through the block.
  always_comb begin
    w_state_nxt = r_state;
    w_tready    = '0;
    w_acc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        w_tready[r_grant] = !r_vld_p0 || lii_out_tready;
        w_acc             = w_tready[r_grant] && s_tvalid[r_grant];
        if (w_acc && s_tlast[r_grant]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Grant register and round-robin pointer. Reset pointer N-1 makes input 0
  // the first candidate.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_ptr   <= IW'(N - 1);
      r_grant <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) r_grant <= w_pick;
      if (w_acc && s_tlast[r_grant])    r_ptr   <= r_grant;
    end
  end

  // Destination table. A write lands on the next edge, so a beat loaded on
  // the same edge as the write still uses the old entry.
  always_ff @(posedge aclk) begin
    if (arst) begin
      for (int i = 0; i < N; i++) r_dst_tab[i] <= 8'h00;
    end else if (cfg_we && (32'(cfg_idx) < N)) begin
      r_dst_tab[cfg_idx] <= cfg_dst;
    end
  end

  // ---- stage p0: output beat register ----
  // A load takes priority over the clear. That keeps one beat per cycle when
  // the phy drains and refills the register on the same edge.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_vld_p0   <= 1'b0;
      r_tdata_p0 <= '0;
      r_dst_p0   <= 8'h00;
    end else if (w_acc) begin
      r_vld_p0   <= 1'b1;
      r_tdata_p0 <= w_ext;
      r_dst_p0   <= r_dst_tab[r_grant];
    end else if (r_vld_p0 && lii_out_tready) begin
      r_vld_p0   <= 1'b0;
    end
  end

  assign s_tready       = w_tready;
  assign lii_out_tdata  = r_tdata_p0;
  assign lii_out_tvalid = r_vld_p0;
  assign lii_out_dst    = r_dst_p0;
  assign lii_out_src    = LOCAL_ID;
  assign busy           = (r_state == S_LOCKED);
  assign grant_idx      = r_grant;

endmodule

// File: tb/tb_lii_out_arbiter.sv
module tb_lii_out_arbiter;

  localparam int         N   = 4;
  localparam int         W   = 72;
  localparam int         PW  = 128;
  localparam logic [7:0] LID = 8'h5A;

  logic            aclk = 1'b0;
  logic            arst;
  logic [N*W-1:0]  s_tdata;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic            cfg_we;
  logic [1:0]      cfg_idx;
  logic [7:0]      cfg_dst;
  logic [PW-1:0]   o_tdata;
  logic            o_tvalid, o_tready;
  logic [7:0]      o_src, o_dst;
  logic            busy;
  logic [1:0]      grant_idx;

  // Small instance with N=3 so that cfg_idx can address the entry N.
  logic [23:0]     sm_tdata;
  logic [2:0]      sm_tvalid, sm_tlast, sm_tready;
  logic            sm_we;
  logic [1:0]      sm_idx;
  logic [7:0]      sm_cdst;
  logic [15:0]     sm_out;
  logic            sm_vld;
  logic [7:0]      sm_src, sm_dst;
  logic            sm_busy;
  logic [1:0]      sm_gnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  lii_out_arbiter #(.N(N), .W(W), .PW(PW), .LOCAL_ID(LID)) dut (
    .aclk(aclk), .arst(arst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_dst(cfg_dst),
    .lii_out_tdata(o_tdata), .lii_out_tvalid(o_tvalid), .lii_out_tready(o_tready),
    .lii_out_src(o_src), .lii_out_dst(o_dst), .busy(busy), .grant_idx(grant_idx)
  );

  lii_out_arbiter #(.N(3), .W(8), .PW(16), .LOCAL_ID(8'h00)) u_small (
    .aclk(aclk), .arst(arst),
    .s_tdata(sm_tdata), .s_tvalid(sm_tvalid), .s_tlast(sm_tlast), .s_tready(sm_tready),
    .cfg_we(sm_we), .cfg_idx(sm_idx), .cfg_dst(sm_cdst),
    .lii_out_tdata(sm_out), .lii_out_tvalid(sm_vld), .lii_out_tready(1'b1),
    .lii_out_src(sm_src), .lii_out_dst(sm_dst), .busy(sm_busy), .grant_idx(sm_gnt)
  );

  typedef struct {
    logic       rst;
    logic [3:0] v, l;
    logic [31:0] d;
    logic       rdy, we;
    logic [1:0] idx;
    logic [7:0] cd;
    logic       etv;
    logic [7:0] eb, edst;
    logic       ebusy;
    logic [1:0] eg;
    logic [3:0] erdy;
  } vec_t;

  vec_t vq[$];

  // Payload of input i: byte b in bits [7:0] and again in [71:64].
  function automatic logic [N*W-1:0] mk(input logic [31:0] d);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = {d[i*8 +: 8], 56'h0, d[i*8 +: 8]};
    return r;
  endfunction

  function automatic logic [PW-1:0] ext(input logic [7:0] b);
    return {56'h0, b, 56'h0, b};
  endfunction

  task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic rdy, input logic we,
                     input logic [1:0] idx, input logic [7:0] cd, input logic etv,
                     input logic [7:0] eb, input logic [7:0] edst, input logic ebusy,
                     input logic [1:0] eg, input logic [3:0] erdy);
    vq.push_back('{rst, v, l, d, rdy, we, idx, cd, etv, eb, edst, ebusy, eg, erdy});
  endtask

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_beat(input string nm, input logic [7:0] b, input logic [7:0] dst);
    chk({nm, " tvalid"}, PW'(o_tvalid), PW'(1'b1));
    chk({nm, " tdata"},  o_tdata, ext(b));
    chk({nm, " dst"},    PW'(o_dst), PW'(dst));
  endtask

  initial begin
    arst = 1'b1; s_tdata = '0; s_tvalid = '0; s_tlast = '0; o_tready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_dst = '0;
    sm_tdata = '0; sm_tvalid = '0; sm_tlast = '0; sm_we = 1'b0; sm_idx = '0; sm_cdst = '0;

    // reset, table write, 3-beat packet on input 2
    add(1, 4'h0, 4'h0, 32'h0,        1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4'b0000);
    add(0, 4'h0, 4'h0, 32'h0,        1, 1, 2, 8'h05, 0, 8'h00, 8'h00, 0, 0, 4'b0000);
    add(0, 4'h4, 4'h0, 32'h00A10000, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 2, 4'b0100);
    add(0, 4'h4, 4'h0, 32'h00A10000, 1, 0, 0, 8'h00, 1, 8'hA1, 8'h05, 1, 2, 4'b0100);
    add(0, 4'h4, 4'h0, 32'h00A20000, 1, 0, 0, 8'h00, 1, 8'hA2, 8'h05, 1, 2, 4'b0100);
    add(0, 4'h4, 4'h4, 32'h00A30000, 1, 0, 0, 8'h00, 1, 8'hA3, 8'h05, 0, 2, 4'b0000);
    add(0, 4'h0, 4'h0, 32'h0,        1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 2, 4'b0000);
    // reset again, then round-robin with 1-beat packets on all inputs
    add(1, 4'h0, 4'h0, 32'h0,        1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4'b0000);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 4'b0001);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 1, 8'h01, 8'h00, 0, 0, 4'b0000);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 4'b0010);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 1, 8'h02, 8'h00, 0, 1, 4'b0000);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 2, 4'b0100);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 1, 8'h03, 8'h00, 0, 2, 4'b0000);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 3, 4'b1000);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 1, 8'h04, 8'h00, 0, 3, 4'b0000);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 4'b0001);
    add(0, 4'hF, 4'hF, 32'h04030201, 1, 0, 0, 8'h00, 1, 8'h01, 8'h00, 0, 0, 4'b0000);
    add(0, 4'h0, 4'h0, 32'h0,        1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 4'b0000);

    foreach (vq[i]) begin
      arst = vq[i].rst; s_tvalid = vq[i].v; s_tlast = vq[i].l; s_tdata = mk(vq[i].d);
      o_tready = vq[i].rdy; cfg_we = vq[i].we; cfg_idx = vq[i].idx; cfg_dst = vq[i].cd;
      step();
      chk($sformatf("v%0d tvalid", i), PW'(o_tvalid), PW'(vq[i].etv));
      chk($sformatf("v%0d busy", i),   PW'(busy),     PW'(vq[i].ebusy));
      chk($sformatf("v%0d grant", i),  PW'(grant_idx), PW'(vq[i].eg));
      chk($sformatf("v%0d s_tready", i), PW'(s_tready), PW'(vq[i].erdy));
      chk($sformatf("v%0d src", i),    PW'(o_src),    PW'(LID));
      if (vq[i].etv) begin
        chk($sformatf("v%0d tdata", i), o_tdata, ext(vq[i].eb));
        chk($sformatf("v%0d dst", i),   PW'(o_dst), PW'(vq[i].edst));
      end
    end
    cfg_we = 1'b0;

    // Packet lock: input 1 sends 4 beats with a 2-cycle gap; input 0 waits.
    s_tvalid = 4'b0011; s_tlast = 4'b0001; s_tdata = mk(32'h0000B110);
    step(); chk("lock grant1", PW'(grant_idx), PW'(2'd1));
    step(); chk_beat("lock B1", 8'hB1, 8'h00);
    s_tdata = mk(32'h0000B210);
    step(); chk_beat("lock B2", 8'hB2, 8'h00);
    s_tvalid = 4'b0001;
    step(); chk("gap1 tvalid", PW'(o_tvalid), PW'(1'b0));
    chk("gap1 busy", PW'(busy), PW'(1'b1));
    chk("gap1 grant", PW'(grant_idx), PW'(2'd1));
    step(); chk("gap2 s_tready", PW'(s_tready), PW'(4'b0010));
    chk("gap2 tvalid", PW'(o_tvalid), PW'(1'b0));
    s_tvalid = 4'b0011; s_tdata = mk(32'h0000B310);
    step(); chk_beat("lock B3", 8'hB3, 8'h00);
    s_tlast = 4'b0011; s_tdata = mk(32'h0000B410);
    step(); chk_beat("lock B4", 8'hB4, 8'h00);
    chk("lock B4 busy", PW'(busy), PW'(1'b0));
    s_tvalid = 4'b0001;
    step(); chk("lock next grant0", PW'(grant_idx), PW'(2'd0));
    step(); chk_beat("lock in0", 8'h10, 8'h00);
    s_tvalid = 4'b0000; s_tlast = 4'b0000;
    step();

    // Back-pressure on input 1 for 5 cycles.
    s_tvalid = 4'b0010; s_tdata = mk(32'h0000C100);
    step(); chk("bp grant1", PW'(grant_idx), PW'(2'd1));
    step(); chk_beat("bp C1", 8'hC1, 8'h00);
    s_tdata = mk(32'h0000C200); o_tready = 1'b0;
    #1 chk("bp ready low", PW'(s_tready), PW'(4'b0000));
    for (int k = 0; k < 5; k++) begin
      step();
      chk_beat($sformatf("bp hold%0d", k), 8'hC1, 8'h00);
      chk($sformatf("bp hold%0d s_tready", k), PW'(s_tready), PW'(4'b0000));
    end
    o_tready = 1'b1;
    #1 chk("bp release s_tready", PW'(s_tready), PW'(4'b0010));
    step(); chk_beat("bp C2", 8'hC2, 8'h00);
    s_tdata = mk(32'h0000C300); s_tlast = 4'b0010;
    step(); chk_beat("bp C3", 8'hC3, 8'h00);
    s_tvalid = 4'b0000; s_tlast = 4'b0000;
    step(); chk("bp drained", PW'(o_tvalid), PW'(1'b0));

    // Destination table change mid-packet on input 2.
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_dst = 8'h11;
    step(); cfg_we = 1'b0;
    s_tvalid = 4'b0100; s_tdata = mk(32'h00D10000);
    step(); chk("cfg grant2", PW'(grant_idx), PW'(2'd2));
    step(); chk_beat("cfg D1", 8'hD1, 8'h11);
    s_tvalid = 4'b0000; cfg_we = 1'b1; cfg_dst = 8'h22;
    step(); cfg_we = 1'b0;
    s_tvalid = 4'b0100; s_tdata = mk(32'h00D20000);
    step(); chk_beat("cfg D2", 8'hD2, 8'h22);
    s_tlast = 4'b0100; s_tdata = mk(32'h00D30000);
    step(); chk_beat("cfg D3", 8'hD3, 8'h22);
    s_tvalid = 4'b0000; s_tlast = 4'b0000;
    step();

    // Reset in the middle of a packet on input 3.
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_dst = 8'h33;
    step(); cfg_we = 1'b0;
    s_tvalid = 4'b1001; s_tlast = 4'b0001; s_tdata = mk(32'hE10000F0);
    step(); chk("rst grant3", PW'(grant_idx), PW'(2'd3));
    step(); chk_beat("rst E1", 8'hE1, 8'h33);
    s_tdata = mk(32'hE20000F0); arst = 1'b1;
    step();
    chk("rst tvalid", PW'(o_tvalid), PW'(1'b0));
    chk("rst tdata", o_tdata, '0);
    chk("rst dst", PW'(o_dst), '0);
    chk("rst busy", PW'(busy), PW'(1'b0));
    chk("rst grant", PW'(grant_idx), PW'(2'd0));
    chk("rst s_tready", PW'(s_tready), PW'(4'b0000));
    chk("rst src", PW'(o_src), PW'(LID));
    arst = 1'b0;
    step(); chk("post-rst grant0", PW'(grant_idx), PW'(2'd0));
    chk("post-rst busy", PW'(busy), PW'(1'b1));
    step(); chk_beat("post-rst F0", 8'hF0, 8'h00);
    s_tvalid = 4'b1000; s_tlast = 4'b1000; s_tdata = mk(32'hE3000000);
    step(); chk("post-rst grant3", PW'(grant_idx), PW'(2'd3));
    step(); chk_beat("post-rst E3 cleared tab", 8'hE3, 8'h00);
    s_tvalid = 4'b0000; s_tlast = 4'b0000;
    step();

    // Out-of-range table index on the N=3 instance, then a valid write.
    sm_we = 1'b1; sm_idx = 2'd3; sm_cdst = 8'h77;
    step(); sm_we = 1'b0;
    sm_tvalid = 3'b001; sm_tlast = 3'b001; sm_tdata = 24'h00005A;
    step(); step();
    chk("sm idx=N tvalid", PW'(sm_vld), PW'(1'b1));
    chk("sm idx=N tdata", PW'(sm_out), PW'(16'h005A));
    chk("sm idx=N dst", PW'(sm_dst), PW'(8'h00));
    sm_tvalid = 3'b000;
    sm_we = 1'b1; sm_idx = 2'd1; sm_cdst = 8'h41;
    step(); sm_we = 1'b0;
    sm_tvalid = 3'b010; sm_tlast = 3'b010; sm_tdata = 24'h006B00;
    step(); step();
    chk("sm idx1 tdata", PW'(sm_out), PW'(16'h006B));
    chk("sm idx1 dst", PW'(sm_dst), PW'(8'h41));
    sm_tvalid = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
